// File: rtl/reg_dump_reader.sv
// Register-file dump sequencer: walks first_reg..last_reg on the combinational
// read port and streams (index, value) pairs out over a valid/ready handshake.
module reg_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic              click,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    always_ff @(posedge click) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (first_reg <= last_reg) begin
                        cur_d   = first_reg;
                        end_d   = last_reg;
                        state_d = S_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                // Register 0 is hardwired zero; optionally step over it without a word.
                if ((SKIP_ZERO != 0) && (cur_q == '0)) begin
                    if (cur_q == end_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d = cur_q + ADDR_W'(1);
                    end
                end else begin
                    data_d  = rd_data;
                    index_d = cur_q;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    // Stop on end rather than incrementing, so last_reg at the top never wraps.
                    if (cur_q == end_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_addr   = cur_q;
    assign out_valid = valid_q;
    assign out_index = index_q;
    assign out_data  = data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: one instance per SKIP_ZERO setting, shared stimulus,
// words checked against per-instance expected queues built from the register image.
module tb_reg_dump_reader;
    localparam int AW = 5;
    localparam int DW = 32;

    logic click = 1'b0;
    always #5 click = ~click;

    logic          Reset, start, out_ready;
    logic [AW-1:0] first_reg, last_reg;
    logic [DW-1:0] regs [32];

    logic [AW-1:0] rd_addr0, idx0, rd_addr1, idx1;
    logic [DW-1:0] rd_data0, data0, rd_data1, data1;
    logic          vld0, busy0, done0, err0, vld1, busy1, done1, err1;

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

    reg_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) dut0 (
        .click(click), .Reset(Reset), .start(start), .first_reg(first_reg),
        .last_reg(last_reg), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_valid(vld0), .out_ready(out_ready), .out_index(idx0),
        .out_data(data0), .busy(busy0), .done(done0), .err(err0));

    reg_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) dut1 (
        .click(click), .Reset(Reset), .start(start), .first_reg(first_reg),
        .last_reg(last_reg), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(vld1), .out_ready(out_ready), .out_index(idx1),
        .out_data(data1), .busy(busy1), .done(done1), .err(err1));

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } word_t;

    word_t q0[$];
    word_t q1[$];
    int errors = 0;
    int checks = 0;
    int done_cnt0 = 0, done_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Handshake sampled at negedge: valid && ready here means accepted at the next posedge.
    always @(negedge click) begin
        word_t w;
        if (Reset) begin
            if (done0) done_cnt0++;
            if (err0)  err_cnt0++;
            if (done0 || err0) check_eq("err_done_excl0", {done0, err0} == 2'b11, 1'b0);
            if (vld0 && out_ready) begin
                check_eq("word0_expected", q0.size() > 0, 1'b1);
                if (q0.size() > 0) begin
                    w = q0.pop_front();
                    check_eq("word0_idx", idx0, w.idx);
                    check_eq("word0_data", data0, w.data);
                end
            end
        end
    end

    always @(negedge click) begin
        word_t w;
        if (Reset) begin
            if (done1) done_cnt1++;
            if (err1)  err_cnt1++;
            if (done1 || err1) check_eq("err_done_excl1", {done1, err1} == 2'b11, 1'b0);
            if (vld1 && out_ready) begin
                check_eq("word1_expected", q1.size() > 0, 1'b1);
                if (q1.size() > 0) begin
                    w = q1.pop_front();
                    check_eq("word1_idx", idx1, w.idx);
                    check_eq("word1_data", data1, w.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge click);
        #1;
    endtask

    // Builds the expected streams from the register image, then pulses start.
    task automatic start_dump(input int f, input int l);
        if (f <= l) begin
            for (int i = f; i <= l; i++) begin
                q0.push_back({AW'(i), regs[i]});
                if (i != 0) q1.push_back({AW'(i), regs[i]});
            end
        end
        first_reg = AW'(f);
        last_reg  = AW'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while ((busy0 || busy1) && n < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check_eq("idle_within_budget", n < budget, 1'b1);
    endtask

    task automatic end_check(input string tag, input int d0, input int d1, input int nd0, input int nd1);
        check_eq({tag, "_q0_empty"}, q0.size(), 0);
        check_eq({tag, "_q1_empty"}, q1.size(), 0);
        check_eq({tag, "_done0"}, done_cnt0 - d0, nd0);
        check_eq({tag, "_done1"}, done_cnt1 - d1, nd1);
        check_eq({tag, "_busy"}, {busy0, busy1}, 2'b00);
    endtask

    initial begin
        int d0, d1, e0, e1, n, f, l;
        Reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        first_reg = '0; last_reg = '0;
        for (int i = 0; i < 32; i++) regs[i] = DW'(i * 16);
        repeat (3) tick();
        check_eq("reset_state0", {vld0, busy0, done0, err0, idx0, data0, rd_addr0}, '0);
        check_eq("reset_state1", {vld1, busy1, done1, err1, idx1, data1, rd_addr1}, '0);
        Reset = 1'b1;
        tick();

        // Basic dump 0..3 with ready held high.
        out_ready = 1'b1;
        d0 = done_cnt0; d1 = done_cnt1;
        start_dump(0, 3);
        wait_idle(100, 1'b0);
        end_check("dump0_3", d0, d1, 1, 1);

        // Backpressure on 5..6; also checks start-to-valid latency and fetch-time capture.
        out_ready = 1'b0;
        d0 = done_cnt0; d1 = done_cnt1;
        start_dump(5, 6);
        check_eq("lat_busy", busy0, 1'b1);
        check_eq("lat_no_valid_yet", vld0, 1'b0);
        tick();
        check_eq("lat_valid", vld0, 1'b1);
        check_eq("bp_first_word", {idx0, data0}, {AW'(5), DW'(32'h50)});
        for (int c = 0; c < 10; c++) begin
            if (c == 0) regs[5] = 32'hDEAD_BEEF;
            tick();
            check_eq("bp_hold", {vld0, idx0, data0}, {1'b1, AW'(5), DW'(32'h50)});
        end
        regs[5] = 32'h50;
        out_ready = 1'b1;
        wait_idle(50, 1'b0);
        end_check("bp", d0, d1, 1, 1);

        // first > last: error pulse only.
        d0 = done_cnt0; d1 = done_cnt1; e0 = err_cnt0; e1 = err_cnt1;
        start_dump(9, 4);
        check_eq("err_pulse", {err0, err1, busy0, busy1}, 4'b1100);
        tick();
        check_eq("err_cleared", {err0, err1, vld0, vld1}, 4'b0000);
        tick();
        check_eq("err_cnt0", err_cnt0 - e0, 1);
        check_eq("err_cnt1", err_cnt1 - e1, 1);
        end_check("err", d0, d1, 0, 0);

        // Register 0 handling, including the single-register-zero dump.
        d0 = done_cnt0; d1 = done_cnt1;
        start_dump(0, 1);
        wait_idle(50, 1'b0);
        end_check("skip0_1", d0, d1, 1, 1);
        d0 = done_cnt0; d1 = done_cnt1;
        start_dump(0, 0);
        wait_idle(50, 1'b0);
        end_check("skip0_0", d0, d1, 1, 1);

        // Start pulse during a full dump is ignored.
        d0 = done_cnt0; d1 = done_cnt1;
        start_dump(0, 31);
        repeat (5) tick();
        first_reg = AW'(7); last_reg = AW'(8); start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(300, 1'b0);
        end_check("mid_start", d0, d1, 1, 1);

        // Reset while word 2 is pending, then a dump at the top of the address range.
        start_dump(0, 3);
        n = 0;
        while (!(vld0 && idx0 == AW'(2)) && n < 40) begin
            tick();
            n++;
        end
        check_eq("reached_word2", {vld0, idx0, data0}, {1'b1, AW'(2), DW'(32'h20)});
        out_ready = 1'b0;
        Reset = 1'b0;
        q0.delete();
        q1.delete();
        d0 = done_cnt0; d1 = done_cnt1;
        tick();
        Reset = 1'b1;
        check_eq("rst_abort", {vld0, busy0, busy1, done0, done1}, 5'b0);
        tick();
        out_ready = 1'b1;
        start_dump(30, 31);
        wait_idle(50, 1'b0);
        end_check("top_range", d0, d1, 0 + 1, 0 + 1);
        repeat (4) tick();
        check_eq("no_wrap", {vld0, vld1, busy0, busy1}, 4'b0000);

        // Randomized dumps with random register contents and random ready.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = $urandom_range(0, 31);
            l = (it % 5 == 4) ? f : $urandom_range(0, 31);
            d0 = done_cnt0; d1 = done_cnt1; e0 = err_cnt0; e1 = err_cnt1;
            start_dump(f, l);
            if (f <= l) begin
                wait_idle(400, 1'b1);
                end_check("rand", d0, d1, 1, 1);
            end else begin
                tick();
                tick();
                check_eq("rand_err0", err_cnt0 - e0, 1);
                check_eq("rand_err1", err_cnt1 - e1, 1);
                end_check("rand_err", d0, d1, 0, 0);
            end
            out_ready = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
